// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control path: controller states, instruction
// classes, opcode/op constants, memory command and write-back select codes.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPD_PC,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WB,
        S_WR_IMM,
        S_ADDR,
        S_LD_ADDR,
        S_MEM_RD1,
        S_MEM_RD2,
        S_STR_B,
        S_STR_EXEC,
        S_MEM_WR,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_UNDEF,
        C_MOV_IMM,
        C_MOV_REG,
        C_ADD,
        C_CMP,
        C_AND,
        C_MVN,
        C_LDR,
        C_STR,
        C_HALT
    } instr_class_t;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_IMM8 = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;

    // Classes whose address or first operand comes from Rn via the A register.
    function automatic logic uses_rn_a(input instr_class_t c);
        return (c == C_ADD) || (c == C_CMP) || (c == C_AND) ||
               (c == C_LDR) || (c == C_STR);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register: register/shift fields and
// the instruction class used by the controller to pick its state path.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [3:0]  cls
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    always_comb begin
        cls = C_UNDEF;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)      cls = C_MOV_IMM;
                else if (op == OP_MOV_REG) cls = C_MOV_REG;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD:  cls = C_ADD;
                    OP_CMP:  cls = C_CMP;
                    OP_AND:  cls = C_AND;
                    default: cls = C_MVN;
                endcase
            end
            OPC_LDR:  if (op == 2'b00) cls = C_LDR;
            OPC_STR:  if (op == 2'b00) cls = C_STR;
            OPC_HALT: if (op == 2'b00) cls = C_HALT;
            default:  cls = C_UNDEF;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Moore fetch/decode/execute sequencer driving the CPU datapath and memory.
// Optional CPU_CTRL_ILLEGAL_TRAP_EN: undefined encodings halt with illegal=1.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic [2:0]  reg_sel,
    output logic        w_en,
    output logic [1:0]  wb_sel,
    output logic        en_A,
    output logic        en_B,
    output logic        en_C,
    output logic        en_status,
    output logic        sel_A,
    output logic        sel_B,
    output logic [1:0]  alu_op,
    output logic [1:0]  shift,
    output logic        halted,
    output logic        illegal
);

    state_t       state;
    state_t       next;
    instr_class_t cls;
    logic [3:0]   cls_raw;
    logic [1:0]   op;
    logic [2:0]   rn;
    logic [2:0]   rd;
    logic [1:0]   sh;
    logic [2:0]   rm;

    instr_decode u_decode (
        .ir  (ir),
        .op  (op),
        .rn  (rn),
        .rd  (rd),
        .sh  (sh),
        .rm  (rm),
        .cls (cls_raw)
    );

    assign cls = instr_class_t'(cls_raw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RST;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_RST:    next = S_IF1;
            S_IF1:    next = S_IF2;
            S_IF2:    next = S_UPD_PC;
            S_UPD_PC: next = S_DECODE;
            S_DECODE: begin
                if (cls == C_MOV_IMM)                        next = S_WR_IMM;
                else if (cls == C_MOV_REG || cls == C_MVN)   next = S_GET_B;
                else if (uses_rn_a(cls))                     next = S_GET_A;
                else if (cls == C_HALT)                      next = S_HALT;
                else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    next = S_HALT;
`else
                    next = S_IF1;
`endif
                end
            end
            S_GET_A:    next = (cls == C_LDR || cls == C_STR) ? S_ADDR : S_GET_B;
            S_GET_B:    next = S_EXEC;
            S_EXEC:     next = (cls == C_CMP) ? S_IF1 : S_WB;
            S_WB:       next = S_IF1;
            S_WR_IMM:   next = S_IF1;
            S_ADDR:     next = S_LD_ADDR;
            S_LD_ADDR:  next = (cls == C_LDR) ? S_MEM_RD1 : S_STR_B;
            S_MEM_RD1:  next = S_MEM_RD2;
            S_MEM_RD2:  next = S_IF1;
            S_STR_B:    next = S_STR_EXEC;
            S_STR_EXEC: next = S_MEM_WR;
            S_MEM_WR:   next = S_IF1;
            S_HALT:     next = S_HALT;
            default:    next = S_RST;
        endcase
    end

    always_comb begin
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MEM_NONE;
        reg_sel   = 3'd0;
        w_en      = 1'b0;
        wb_sel    = WB_ALU;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_status = 1'b0;
        sel_A     = 1'b0;
        sel_B     = 1'b0;
        alu_op    = 2'b00;
        shift     = 2'b00;
        halted    = 1'b0;
        case (state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_RD;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_RD;
                load_ir  = 1'b1;
            end
            S_UPD_PC: load_pc = 1'b1;
            S_WR_IMM: begin
                reg_sel = rn;
                wb_sel  = WB_IMM8;
                w_en    = 1'b1;
            end
            S_GET_A: begin
                reg_sel = rn;
                en_A    = 1'b1;
            end
            S_GET_B: begin
                reg_sel = rm;
                en_B    = 1'b1;
            end
            // MOV reg passes shifted B through an ALU add with A forced to zero.
            S_EXEC: begin
                shift = sh;
                if (cls == C_MOV_REG) begin
                    sel_A  = 1'b1;
                    alu_op = 2'b00;
                end else begin
                    alu_op = op;
                end
                if (cls == C_CMP) en_status = 1'b1;
                else              en_C      = 1'b1;
            end
            S_WB: begin
                reg_sel = rd;
                wb_sel  = WB_ALU;
                w_en    = 1'b1;
            end
            S_ADDR: begin
                sel_B = 1'b1;
                en_C  = 1'b1;
            end
            S_LD_ADDR: load_addr = 1'b1;
            S_MEM_RD1: mem_cmd = MEM_RD;
            S_MEM_RD2: begin
                mem_cmd = MEM_RD;
                reg_sel = rd;
                wb_sel  = WB_MEM;
                w_en    = 1'b1;
            end
            S_STR_B: begin
                reg_sel = rd;
                en_B    = 1'b1;
            end
            S_STR_EXEC: begin
                sel_A = 1'b1;
                en_C  = 1'b1;
            end
            S_MEM_WR: mem_cmd = MEM_WR;
            S_HALT:   halted  = 1'b1;
            default: ;
        endcase
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    // Remembers why HALT was entered; only a reset clears it.
    logic trap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   trap_q <= 1'b0;
        else if (state == S_DECODE && cls == C_UNDEF) trap_q <= 1'b1;
    end

    assign illegal = (state == S_HALT) && trap_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: instruction-level reference model feeding an expected
// per-cycle output queue, with an IR model and a negedge monitor.
module tb_cpu_ctrl;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic [2:0] reg_sel;
        logic       w_en;
        logic [1:0] wb_sel;
        logic       en_a;
        logic       en_b;
        logic       en_c;
        logic       en_status;
        logic       sel_a;
        logic       sel_b;
        logic [1:0] alu_op;
        logic [1:0] shift;
        logic       halted;
        logic       illegal;
    } out_t;

    localparam int W = $bits(out_t);

    logic        clk;
    logic        rst_n;
    logic [15:0] ir;
    logic        load_ir, load_pc, reset_pc, load_addr, addr_sel;
    logic [1:0]  mem_cmd;
    logic [2:0]  reg_sel;
    logic        w_en;
    logic [1:0]  wb_sel;
    logic        en_A, en_B, en_C, en_status, sel_A, sel_B;
    logic [1:0]  alu_op, shift;
    logic        halted, illegal;

    logic [W-1:0]  exp_q[$];
    logic [15:0]   prog_q[$];
    logic [W-1:0]  act;
    logic          mon_en;
    int            total;
    int            bad;
    int            cyc;

    cpu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .load_addr (load_addr),
        .addr_sel  (addr_sel),
        .mem_cmd   (mem_cmd),
        .reg_sel   (reg_sel),
        .w_en      (w_en),
        .wb_sel    (wb_sel),
        .en_A      (en_A),
        .en_B      (en_B),
        .en_C      (en_C),
        .en_status (en_status),
        .sel_A     (sel_A),
        .sel_B     (sel_B),
        .alu_op    (alu_op),
        .shift     (shift),
        .halted    (halted),
        .illegal   (illegal)
    );

    assign act = {load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd,
                  reg_sel, w_en, wb_sel, en_A, en_B, en_C, en_status,
                  sel_A, sel_B, alu_op, shift, halted, illegal};

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic out_t rst_vec();
        out_t v = '0;
        v.reset_pc = 1'b1;
        v.load_pc  = 1'b1;
        return v;
    endfunction

    task automatic push(input out_t v);
        exp_q.push_back(W'(v));
    endtask

    task automatic push_fetch();
        out_t v = '0;
        v.addr_sel = 1'b1;
        v.mem_cmd  = 2'b01;
        push(v);
        v.load_ir = 1'b1;
        push(v);
        v = '0;
        v.load_pc = 1'b1;
        push(v);
        v = '0;
        push(v);
    endtask

    task automatic push_halt(input logic ill);
        out_t v = '0;
        v.halted  = 1'b1;
        v.illegal = ill;
        repeat (6) push(v);
    endtask

    task automatic issue(input logic [15:0] w);
        logic [2:0] opc = w[15:13];
        logic [1:0] op  = w[12:11];
        logic [2:0] rn  = w[10:8];
        logic [2:0] rd  = w[7:5];
        logic [1:0] sh  = w[4:3];
        logic [2:0] rm  = w[2:0];
        logic       is_mov;
        out_t       v;
        prog_q.push_back(w);
        push_fetch();
        if (opc == 3'b110 && op == 2'b10) begin
            v = '0; v.reg_sel = rn; v.wb_sel = 2'b01; v.w_en = 1'b1; push(v);
        end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
            is_mov = (opc == 3'b110);
            if (!is_mov && op != 2'b11) begin
                v = '0; v.reg_sel = rn; v.en_a = 1'b1; push(v);
            end
            v = '0; v.reg_sel = rm; v.en_b = 1'b1; push(v);
            v = '0;
            v.shift  = sh;
            v.sel_a  = is_mov;
            v.alu_op = is_mov ? 2'b00 : op;
            if (!is_mov && op == 2'b01) v.en_status = 1'b1;
            else                        v.en_c      = 1'b1;
            push(v);
            if (is_mov || op != 2'b01) begin
                v = '0; v.reg_sel = rd; v.w_en = 1'b1; push(v);
            end
        end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
            v = '0; v.reg_sel = rn; v.en_a = 1'b1; push(v);
            v = '0; v.sel_b = 1'b1; v.en_c = 1'b1; push(v);
            v = '0; v.load_addr = 1'b1; push(v);
            if (opc == 3'b011) begin
                v = '0; v.mem_cmd = 2'b01; push(v);
                v.reg_sel = rd; v.wb_sel = 2'b10; v.w_en = 1'b1; push(v);
            end else begin
                v = '0; v.reg_sel = rd; v.en_b = 1'b1; push(v);
                v = '0; v.sel_a = 1'b1; v.en_c = 1'b1; push(v);
                v = '0; v.mem_cmd = 2'b10; push(v);
            end
        end else if (opc == 3'b111 && op == 2'b00) begin
            push_halt(1'b0);
        end else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            push_halt(1'b1);
`endif
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w = 16'($urandom);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        int k = $urandom_range(0, 5);
`else
        int k = $urandom_range(0, 6);
`endif
        case (k)
            0:       w[15:11] = 5'b11010;
            1:       w[15:11] = 5'b11000;
            2, 3:    w[15:13] = 3'b101;
            4:       w[15:11] = 5'b01100;
            5:       w[15:11] = 5'b10000;
            default: w[15:13] = 3'($urandom_range(0, 2));
        endcase
        return w;
    endfunction

    // ---------------- IR register model ----------------
    initial begin
        logic ld;
        forever begin
            @(negedge clk);
            ld = load_ir;
            @(posedge clk);
            if (ld && prog_q.size() > 0) ir = prog_q.pop_front();
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got=%h expected=%h ir=%h", cyc, act, e, ir);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_rst(input string name);
        total++;
        if (act !== W'(rst_vec())) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, W'(rst_vec()));
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        exp_q.delete();
        prog_q.delete();
        @(posedge clk);
        #1 check_rst("reset_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(rst_vec());
        mon_en = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d_left required=0_left", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        out_t v;
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        ir     = 16'h0000;
        #1 check_rst("reset_async");

        do_reset();
        issue(16'hD107);
        issue(16'hA2E6);
        issue(16'hAB05);
        issue(16'h6025);
        issue(16'h8045);
        issue(16'hC0B9);
        issue(16'hBC4A);
        issue(16'hB0F3);
        issue(16'hE000);
        drain();

        do_reset();
        issue(16'h0000);
`ifndef CPU_CTRL_ILLEGAL_TRAP_EN
        issue(16'hD3FF);
        issue(16'hE000);
`endif
        drain();

        do_reset();
        for (int i = 0; i < 40; i++) issue(rand_instr());
        issue(16'hE000);
        drain();

        // Abort an ADD in GET_B: reset must take effect without waiting for a clock.
        do_reset();
        prog_q.push_back(16'hA2E6);
        push_fetch();
        v = '0; v.reg_sel = 3'd2; v.en_a = 1'b1; push(v);
        v = '0; v.reg_sel = 3'd6; v.en_b = 1'b1; push(v);
        drain();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1 check_rst("reset_mid_get_b");

        do_reset();
        issue(16'hD507);
        issue(16'hE000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
